// File: rtl/pc_pkg.sv
// pc_pkg: shared PC state enum, increments and redirect alignment mask (mask set by PC_COMPRESSED_EN)
package pc_pkg;
  typedef enum logic [1:0] {BOOT, RUN, FAULT} pc_state_t;
  localparam int PC_INC_WORD = 4;
  localparam int PC_INC_HALF = 2;
`ifdef PC_COMPRESSED_EN
  localparam logic [1:0] PC_ALIGN_MASK = 2'b01;
`else
  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;
`endif
endpackage

// File: rtl/pc_align_chk.sv
// pc_align_chk: combinational misalignment detect; target in, misaligned out (mask from pc_pkg, PC_COMPRESSED_EN)
module pc_align_chk
  import pc_pkg::*;
#(
  parameter int ADDRESS = 32
) (
  input  logic [ADDRESS-1:0] target,
  output logic               misaligned
);
  assign misaligned = |(target[1:0] & PC_ALIGN_MASK);
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch PC advancing on accepted handshake with redirect/trap priority and misaligned-redirect FAULT; ports clk rst stall fetch_ready fetch_valid address_out redirect_valid/target trap_valid/vector misaligned fault_addr fetch_count, plus fetch_compressed when PC_COMPRESSED_EN
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDRESS      = 32,
  parameter logic [ADDRESS-1:0] RESET_VECTOR = '0,
  parameter int                COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               fetch_ready,
  output logic               fetch_valid,
  output logic [ADDRESS-1:0] address_out,
  input  logic               redirect_valid,
  input  logic [ADDRESS-1:0] redirect_target,
  input  logic               trap_valid,
  input  logic [ADDRESS-1:0] trap_vector,
  output logic               misaligned,
`ifdef PC_COMPRESSED_EN
  input  logic               fetch_compressed,
`endif
  output logic [ADDRESS-1:0] fault_addr,
  output logic [COUNT_W-1:0] fetch_count
);
  pc_state_t state_q, state_d;
  logic [ADDRESS-1:0] pc_q, pc_d, fault_addr_q, fault_addr_d, inc;
  logic [COUNT_W-1:0] count_q, count_d;
  logic bad_target, accept;
  pc_align_chk #(.ADDRESS(ADDRESS)) u_align (.target(redirect_target), .misaligned(bad_target));
`ifdef PC_COMPRESSED_EN
  assign inc = fetch_compressed ? ADDRESS'(PC_INC_HALF) : ADDRESS'(PC_INC_WORD);
`else
  assign inc = ADDRESS'(PC_INC_WORD);
`endif
  assign fetch_valid = (state_q == RUN) && !stall;
  assign accept      = fetch_valid && fetch_ready;
  assign address_out = pc_q;
  assign misaligned  = state_q == FAULT;
  assign fault_addr  = fault_addr_q;
  assign fetch_count = count_q;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    count_d      = count_q;
    if (trap_valid) begin
      pc_d    = {trap_vector[ADDRESS-1:2], 2'b00};
      state_d = RUN;
    end else if (state_q == BOOT) begin
      state_d = RUN;
    end else if (redirect_valid && state_q == RUN) begin
      state_d      = bad_target ? FAULT : RUN;
      fault_addr_d = bad_target ? redirect_target : fault_addr_q;
      pc_d         = bad_target ? pc_q : redirect_target;
    end else if (accept) begin
      pc_d    = pc_q + inc;
      count_d = count_q + COUNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      fault_addr_q <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit
module tb_pc_unit;
  logic clk = 0, rst = 1, stall = 0, fetch_ready = 0, fetch_valid;
  logic redirect_valid = 0, trap_valid = 0, misaligned, fetch_compressed = 0;
  logic [31:0] address_out, redirect_target = 0, trap_vector = 0, fault_addr, fetch_count;
  int checks = 0, errors = 0;
`ifdef PC_COMPRESSED_EN
  localparam logic [31:0] BAD_TGT = 32'h201;
`else
  localparam logic [31:0] BAD_TGT = 32'h202;
`endif
  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .address_out(address_out), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector), .misaligned(misaligned),
`ifdef PC_COMPRESSED_EN
    .fetch_compressed(fetch_compressed),
`endif
    .fault_addr(fault_addr), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    rst = 0;
    check("rst_addr", address_out, 32'h0);
    check("rst_valid", {31'b0, fetch_valid}, 0);
    check("rst_mis", {31'b0, misaligned}, 0);
    check("rst_fault", fault_addr, 0);
    check("rst_count", fetch_count, 0);
    fetch_ready = 1;
    tick();
    check("boot_addr", address_out, 32'h0);
    check("run_valid", {31'b0, fetch_valid}, 1);
    tick(3);
    check("acc3_addr", address_out, 32'hC);
    check("acc3_count", fetch_count, 3);
    tick();
    fetch_ready = 0;
    tick(5);
    check("hold_addr", address_out, 32'h10);
    check("hold_count", fetch_count, 4);
    stall = 1;
    fetch_ready = 1;
    #1 check("stall_valid", {31'b0, fetch_valid}, 0);
    tick();
    check("stall_addr", address_out, 32'h10);
    stall = 0;
    redirect_valid = 1; redirect_target = 32'h200; trap_valid = 1; trap_vector = 32'h103;
    tick();
    trap_valid = 0;
    check("trap_prio_addr", address_out, 32'h100);
    check("trap_prio_count", fetch_count, 4);
    redirect_target = BAD_TGT;
    tick();
    check("fault_mis", {31'b0, misaligned}, 1);
    check("fault_addr", fault_addr, BAD_TGT);
    check("fault_pc", address_out, 32'h100);
    check("fault_valid", {31'b0, fetch_valid}, 0);
    redirect_target = 32'h300;
    tick();
    check("fault_ign_pc", address_out, 32'h100);
    check("fault_ign_mis", {31'b0, misaligned}, 1);
    redirect_valid = 0; trap_valid = 1; trap_vector = 32'h80;
    tick();
    trap_valid = 0; fetch_ready = 0;
    check("trap_exit_pc", address_out, 32'h80);
    check("trap_exit_mis", {31'b0, misaligned}, 0);
    check("trap_exit_valid", {31'b0, fetch_valid}, 1);
    fetch_ready = 1; redirect_valid = 1; redirect_target = 32'h40;
    tick();
    redirect_valid = 0;
    check("redir_pc", address_out, 32'h40);
    check("redir_count", fetch_count, 4);
    trap_valid = 1; trap_vector = 32'hFFFF_FFFC;
    tick();
    trap_valid = 0;
    check("wrap_pre", address_out, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc", address_out, 32'h0);
    check("wrap_count", fetch_count, 5);
    tick(2);
    check("cnt7", fetch_count, 7);
    redirect_valid = 1; redirect_target = BAD_TGT;
    tick();
    redirect_valid = 0;
    check("fault2_mis", {31'b0, misaligned}, 1);
    rst = 1;
    tick();
    rst = 0;
    check("rst2_pc", address_out, 32'h0);
    check("rst2_mis", {31'b0, misaligned}, 0);
    check("rst2_count", fetch_count, 0);
    check("rst2_fault", fault_addr, 0);
    check("rst2_valid", {31'b0, fetch_valid}, 0);
`ifdef PC_COMPRESSED_EN
    trap_valid = 1; trap_vector = 32'h100;
    tick();
    trap_valid = 0; fetch_compressed = 1;
    tick();
    fetch_compressed = 0;
    check("c_half_pc", address_out, 32'h102);
    redirect_valid = 1; redirect_target = 32'h202;
    tick();
    redirect_valid = 0;
    check("c_redir_pc", address_out, 32'h202);
    check("c_redir_mis", {31'b0, misaligned}, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RV32I fetch stage and the successor to the free-running PC. It holds the fetch address and advances it only on an accepted fetch handshake. It takes branch/jump redirects and trap redirects, and detects misaligned redirect targets. On a misaligned target it parks in a fault state until a trap vector is supplied.

## Interface
Parameters:
- ADDRESS, 32, PC width in bits.
- RESET_VECTOR, 32'h0000_0000, value loaded into address_out on reset.
- COUNT_W, 32, width of the accepted-fetch counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and drop fetch_valid; does not block redirect or trap.
- fetch_ready  input  1  fetch side accepts address_out this cycle.
- fetch_valid  output  1  address_out is a valid fetch request.
- address_out  output  ADDRESS  current fetch address.
- redirect_valid  input  1  branch/jump taken.
- redirect_target  input  ADDRESS  branch/jump destination.
- trap_valid  input  1  trap/exception redirect.
- trap_vector  input  ADDRESS  trap destination; low two bits are forced to 0.
- misaligned  output  1  high while in FAULT.
- fault_addr  output  ADDRESS  offending redirect_target captured on fault entry.
- fetch_count  output  COUNT_W  number of accepted fetches since reset.
- fetch_compressed  input  1  present only with PC_COMPRESSED_EN; accepted instruction is 16-bit.

## Operation
- States:
  - BOOT: after reset.
  - RUN: normal fetching.
  - FAULT: misaligned redirect taken.
- Reset values:
  - address_out = RESET_VECTOR; state = BOOT.
  - fetch_valid = 0, misaligned = 0.
  - fault_addr = 0, fetch_count = 0.
- BOOT → RUN unconditionally after one cycle. The PC does not change in BOOT.
- fetch_valid = (state == RUN) && !stall.
- Accept = fetch_valid && fetch_ready.
  - On accept, address_out += increment and fetch_count += 1.
  - Without accept, address_out holds.
- Priority, evaluated every cycle: rst > trap_valid > redirect_valid > accept.
- trap_valid, in any state:
  - address_out ← {trap_vector[ADDRESS-1:2], 2'b00}, state → RUN, misaligned ← 0.
  - Any same-cycle redirect or accept is discarded and fetch_count does not increment.
- redirect_valid in RUN, aligned target: address_out ← redirect_target; a same-cycle accept is discarded (no increment).
- redirect_valid in RUN, misaligned target: state → FAULT, fault_addr ← redirect_target, misaligned ← 1, address_out holds.
- redirect_valid in BOOT or FAULT: ignored.
- FAULT exits only via trap_valid or rst. stall has no effect on state transitions.
- Wrap-around:
  - address_out 0xFFFF_FFFC + 4 → 0x0000_0000, no flag.
  - fetch_count wraps modulo 2^COUNT_W silently.

## Timing
- All outputs are registered, except fetch_valid, which is decoded from registered state and the stall input.
- Redirect and trap take effect on address_out in the cycle after assertion (1-cycle latency).
- misaligned and fault_addr are visible in the cycle after the faulting redirect.
- Holding fetch_ready low keeps address_out stable indefinitely; there is no timeout.
- rst asserted mid-operation returns every output to its reset value on the next posedge, regardless of pending redirect, trap or fault.

## Configuration
- PC_COMPRESSED_EN defined:
  - fetch_compressed port exists; an accept increments by 2 when fetch_compressed = 1, otherwise by 4.
  - Misaligned means target[0] != 0.
  - Trap vector low bits are still forced to 2'b00.
- PC_COMPRESSED_EN undefined:
  - No fetch_compressed port; increment is always 4.
  - Misaligned means target[1:0] != 2'b00.

## Structure
- Shared package pc_pkg holds:
  - state enum pc_state_t {BOOT, RUN, FAULT};
  - constants PC_INC_WORD = 4 and PC_INC_HALF = 2;
  - the alignment mask constant, selected by PC_COMPRESSED_EN.
- One sub-module, pc_align_chk: combinational misalignment detect on redirect_target. Reused by the branch unit.
- Next-state, next-PC and counter logic live in pc_unit.

## Test plan
- Reset then 3 accepts with fetch_ready = 1 → address_out 0x0, 0x0 (BOOT), 0x4, 0x8, 0xC; fetch_count = 3.
- fetch_ready = 0 for 5 cycles at PC 0x10 → address_out stays 0x10, fetch_count unchanged; stall = 1 → fetch_valid = 0.
- Same cycle: redirect_valid with target 0x200, trap_valid with vector 0x103 → address_out = 0x100 next cycle, no count increment.
- Redirect to 0x202 (macro off) → misaligned = 1, fault_addr = 0x202, fetch_valid = 0. A later redirect is ignored; trap to 0x80 → RUN at 0x80.
- PC 0xFFFF_FFFC accepted → 0x0000_0000. With PC_COMPRESSED_EN, fetch_compressed = 1 at 0x100 → 0x102, and redirect to 0x202 raises no fault.
- rst asserted while in FAULT with fetch_count = 7 → next cycle address_out = RESET_VECTOR, misaligned = 0, fetch_count = 0, state = BOOT.
